// File: rtl/router_fsm_nport.sv
// -----------------------------------------------------------------------------
// router_fsm_nport
//
// Control FSM for an N-port packet router. It sits between the input
// register/synchroniser and the per-port FIFOs. It sequences header decode,
// payload load, FIFO-full stalls and the parity check. It also:
//   - latches a one-hot destination select from the header address,
//   - waits a bounded number of cycles for a busy destination FIFO to drain,
//   - discards packets with an invalid address or a timed-out wait.
//
// Parameters
//   NUM_PORTS     number of destination FIFOs (2..16)
//   ADDR_W        header address width, 2**ADDR_W >= NUM_PORTS
//   WAIT_TIMEOUT  max cycles spent waiting for an empty FIFO (>= 2)
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset          synchronous active-high reset
//   i_pkt_valid      source packet valid
//   i_parity_done    parity byte loaded by the register block
//   i_data_in        header address field
//   i_soft_reset     per-port soft reset (FIFO read timeout)
//   i_fifo_full      full flag of the currently selected FIFO
//   i_low_pkt_valid  pkt_valid fell while the FIFO was full
//   i_fifo_empty     per-port FIFO empty flags
//   o_busy           back-pressure to the source
//   o_detect_addr    in DECODE_ADDRESS
//   o_lfd_state      in LOAD_FIRST_DATA
//   o_ld_state       in LOAD_DATA
//   o_laf_state      in LOAD_AFTER_FULL
//   o_full_state     in FIFO_FULL_STATE
//   o_write_enb_reg  register block may write the FIFO
//   o_rst_int_reg    in CHECK_PARITY_ERROR
//   o_drop_state     in DROP_PACKET, payload discarded
//   o_timeout_err    one-cycle pulse when a wait times out
//   o_dest_sel       one-hot latched destination
// -----------------------------------------------------------------------------
module router_fsm_nport #(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_pkt_valid,
    input  logic                 i_parity_done,
    input  logic [ADDR_W-1:0]    i_data_in,
    input  logic [NUM_PORTS-1:0] i_soft_reset,
    input  logic                 i_fifo_full,
    input  logic                 i_low_pkt_valid,
    input  logic [NUM_PORTS-1:0] i_fifo_empty,
    output logic                 o_busy,
    output logic                 o_detect_addr,
    output logic                 o_lfd_state,
    output logic                 o_ld_state,
    output logic                 o_laf_state,
    output logic                 o_full_state,
    output logic                 o_write_enb_reg,
    output logic                 o_rst_int_reg,
    output logic                 o_drop_state,
    output logic                 o_timeout_err,
    output logic [NUM_PORTS-1:0] o_dest_sel
);

    localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_DA   = 4'd0,  // DECODE_ADDRESS
        S_LFD  = 4'd1,  // LOAD_FIRST_DATA
        S_LD   = 4'd2,  // LOAD_DATA
        S_FFS  = 4'd3,  // FIFO_FULL_STATE
        S_LAF  = 4'd4,  // LOAD_AFTER_FULL
        S_LP   = 4'd5,  // LOAD_PARITY
        S_CPE  = 4'd6,  // CHECK_PARITY_ERROR
        S_WTE  = 4'd7,  // WAIT_TILL_EMPTY
        S_DROP = 4'd8   // DROP_PACKET
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [NUM_PORTS-1:0] r_dest_sel;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic                 r_timeout_err;

    logic [NUM_PORTS-1:0] w_addr_onehot;
    logic                 w_addr_ok;
    logic                 w_empty_da;
    logic                 w_empty_sel;
    logic                 w_soft_hit;
    logic                 w_wait_done;

    // One-hot decode of the header address. An address at or above
    // NUM_PORTS decodes to all zeros, which doubles as the invalid flag.
    always_comb begin
        w_addr_onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_addr_onehot[i] = (i_data_in == ADDR_W'(i));
        end
    end

    assign w_addr_ok   = |w_addr_onehot;
    // In DA the destination is not latched yet, so look at the live address.
    assign w_empty_da  = |(i_fifo_empty & w_addr_onehot);
    assign w_empty_sel = |(i_fifo_empty & r_dest_sel);
    assign w_soft_hit  = (r_state != S_DA) && (|(i_soft_reset & r_dest_sel));
    assign w_wait_done = (r_wait_cnt == CNT_W'(WAIT_TIMEOUT - 1));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_DA;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_DA: begin
                if (i_pkt_valid) begin
                    if (!w_addr_ok) begin
                        w_next = S_DROP;
                    end else if (w_empty_da) begin
                        w_next = S_LFD;
                    end else begin
                        w_next = S_WTE;
                    end
                end
            end
            S_LFD: w_next = S_LD;
            S_LD: begin
                if (i_fifo_full) begin
                    w_next = S_FFS;
                end else if (!i_pkt_valid) begin
                    w_next = S_LP;
                end
            end
            S_FFS: begin
                if (!i_fifo_full) begin
                    w_next = S_LAF;
                end
            end
            S_LAF: begin
                if (i_parity_done) begin
                    w_next = S_DA;
                end else if (i_low_pkt_valid) begin
                    w_next = S_LP;
                end else begin
                    w_next = S_LD;
                end
            end
            S_LP:  w_next = S_CPE;
            S_CPE: w_next = i_fifo_full ? S_FFS : S_DA;
            S_WTE: begin
                // A FIFO that drains on the last allowed cycle still wins.
                if (w_empty_sel) begin
                    w_next = S_LFD;
                end else if (w_wait_done) begin
                    w_next = S_DROP;
                end
            end
            S_DROP: begin
                if (!i_pkt_valid) begin
                    w_next = S_DA;
                end
            end
            default: w_next = S_DA;
        endcase

        // A soft reset on the selected port aborts the packet from any state.
        if (w_soft_hit) begin
            w_next = S_DA;
        end
    end

    // Destination latch, wait counter and timeout pulse
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dest_sel    <= '0;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_soft_hit) begin
                r_dest_sel <= '0;
            end else if ((r_state == S_DA) && i_pkt_valid) begin
                r_dest_sel <= w_addr_onehot;
            end

            // The counter only advances while staying in WTE, so every
            // entry into WTE starts from zero.
            if ((r_state == S_WTE) && (w_next == S_WTE)) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end

            r_timeout_err <= (r_state == S_WTE) && (w_next == S_DROP);
        end
    end

    // Moore outputs
    always_comb begin
        o_busy          = 1'b0;
        o_detect_addr   = 1'b0;
        o_lfd_state     = 1'b0;
        o_ld_state      = 1'b0;
        o_laf_state     = 1'b0;
        o_full_state    = 1'b0;
        o_write_enb_reg = 1'b0;
        o_rst_int_reg   = 1'b0;
        o_drop_state    = 1'b0;
        case (r_state)
            S_DA:   o_detect_addr = 1'b1;
            S_LFD: begin
                o_lfd_state = 1'b1;
                o_busy      = 1'b1;
            end
            S_LD: begin
                o_ld_state      = 1'b1;
                o_write_enb_reg = 1'b1;
            end
            S_FFS: begin
                o_full_state = 1'b1;
                o_busy       = 1'b1;
            end
            S_LAF: begin
                o_laf_state     = 1'b1;
                o_busy          = 1'b1;
                o_write_enb_reg = 1'b1;
            end
            S_LP: begin
                o_busy          = 1'b1;
                o_write_enb_reg = 1'b1;
            end
            S_CPE: begin
                o_rst_int_reg = 1'b1;
                o_busy        = 1'b1;
            end
            S_WTE:  o_busy = 1'b1;
            S_DROP: o_drop_state = 1'b1;
            default: begin
                o_detect_addr = 1'b0;
            end
        endcase
    end

    assign o_timeout_err = r_timeout_err;
    assign o_dest_sel    = r_dest_sel;

endmodule

// File: tb/tb_router_fsm_nport.sv
module tb_router_fsm_nport;

    localparam int NP = 3;
    localparam int AW = 2;
    localparam int WT = 4;

    logic          clk;
    logic          reset;
    logic          pkt_valid;
    logic          parity_done;
    logic [AW-1:0] data_in;
    logic [NP-1:0] soft_reset;
    logic          fifo_full;
    logic          low_pkt_valid;
    logic [NP-1:0] fifo_empty;

    logic          busy, detect_addr, lfd_state, ld_state, laf_state;
    logic          full_state, write_enb_reg, rst_int_reg, drop_state;
    logic          timeout_err;
    logic [NP-1:0] dest_sel;

    logic [9:0]    dut_flags;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    string         m_st;
    logic [NP-1:0] m_dest;
    int            m_wait;
    logic          m_to;

    router_fsm_nport #(
        .NUM_PORTS   (NP),
        .ADDR_W      (AW),
        .WAIT_TIMEOUT(WT)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_pkt_valid    (pkt_valid),
        .i_parity_done  (parity_done),
        .i_data_in      (data_in),
        .i_soft_reset   (soft_reset),
        .i_fifo_full    (fifo_full),
        .i_low_pkt_valid(low_pkt_valid),
        .i_fifo_empty   (fifo_empty),
        .o_busy         (busy),
        .o_detect_addr  (detect_addr),
        .o_lfd_state    (lfd_state),
        .o_ld_state     (ld_state),
        .o_laf_state    (laf_state),
        .o_full_state   (full_state),
        .o_write_enb_reg(write_enb_reg),
        .o_rst_int_reg  (rst_int_reg),
        .o_drop_state   (drop_state),
        .o_timeout_err  (timeout_err),
        .o_dest_sel     (dest_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dut_flags = {busy, detect_addr, lfd_state, ld_state, laf_state,
                        full_state, write_enb_reg, rst_int_reg, drop_state,
                        timeout_err};

    function automatic logic [9:0] exp_flags(input string s, input logic to);
        logic b;
        logic w;
        b = (s == "LFD") || (s == "FFS") || (s == "LAF") || (s == "LP") ||
            (s == "CPE") || (s == "WTE");
        w = (s == "LD") || (s == "LAF") || (s == "LP");
        return {b, (s == "DA"), (s == "LFD"), (s == "LD"), (s == "LAF"),
                (s == "FFS"), w, (s == "CPE"), (s == "DROP"), to};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advances the reference model by one clock using the current inputs.
    task automatic model_step();
        string         n;
        logic [NP-1:0] nd;
        logic          to;
        logic          valid;
        logic          empty_sel;
        if (reset) begin
            m_st   = "DA";
            m_dest = '0;
            m_wait = 0;
            m_to   = 1'b0;
            return;
        end
        n         = m_st;
        nd        = m_dest;
        to        = 1'b0;
        valid     = (int'(data_in) < NP);
        empty_sel = |(fifo_empty & m_dest);
        if (m_st == "DA") begin
            if (pkt_valid) begin
                if (valid) begin
                    nd = NP'(1) << data_in;
                    n  = fifo_empty[data_in] ? "LFD" : "WTE";
                end else begin
                    nd = '0;
                    n  = "DROP";
                end
            end
        end else if (m_st == "LFD") begin
            n = "LD";
        end else if (m_st == "LD") begin
            if (fifo_full) n = "FFS";
            else if (!pkt_valid) n = "LP";
        end else if (m_st == "FFS") begin
            if (!fifo_full) n = "LAF";
        end else if (m_st == "LAF") begin
            if (parity_done) n = "DA";
            else if (low_pkt_valid) n = "LP";
            else n = "LD";
        end else if (m_st == "LP") begin
            n = "CPE";
        end else if (m_st == "CPE") begin
            n = fifo_full ? "FFS" : "DA";
        end else if (m_st == "WTE") begin
            if (empty_sel) n = "LFD";
            else if (m_wait == WT - 1) begin
                n  = "DROP";
                to = 1'b1;
            end
        end else if (m_st == "DROP") begin
            if (!pkt_valid) n = "DA";
        end
        if ((m_st != "DA") && (|(soft_reset & m_dest))) begin
            n  = "DA";
            nd = '0;
            to = 1'b0;
        end
        m_wait = ((m_st == "WTE") && (n == "WTE")) ? m_wait + 1 : 0;
        m_st   = n;
        m_dest = nd;
        m_to   = to;
    endtask

    // One clock: drive inputs, step model on the edge, compare on the falling edge.
    task automatic cyc(input logic rst, pv, pd, input logic [AW-1:0] din,
                       input logic [NP-1:0] sr, input logic ff, lpv,
                       input logic [NP-1:0] fe);
        reset         = rst;
        pkt_valid     = pv;
        parity_done   = pd;
        data_in       = din;
        soft_reset    = sr;
        fifo_full     = ff;
        low_pkt_valid = lpv;
        fifo_empty    = fe;
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk({"flags@", m_st}, 32'(dut_flags), 32'(exp_flags(m_st, m_to)));
        chk({"dest_sel@", m_st}, 32'(dest_sel), 32'(m_dest));
    endtask

    initial begin
        m_st = "DA"; m_dest = '0; m_wait = 0; m_to = 1'b0;
        reset = 1'b1; pkt_valid = 1'b0; parity_done = 1'b0; data_in = '0;
        soft_reset = '0; fifo_full = 1'b0; low_pkt_valid = 1'b0; fifo_empty = '0;

        // Reset state
        cyc(1, 0, 0, 2'd0, 3'b000, 0, 0, 3'b000);
        cyc(1, 1, 0, 2'd0, 3'b000, 0, 0, 3'b000);
        chk("rst_detect", 32'(detect_addr), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dest", 32'(dest_sel), 32'd0);

        // Simple packet to port 0
        cyc(0, 1, 0, 2'd0, 3'b000, 0, 0, 3'b001);
        chk("p0_lfd", 32'(lfd_state), 32'd1);
        chk("p0_dest", 32'(dest_sel), 32'b001);
        cyc(0, 1, 0, 2'd0, 3'b000, 0, 0, 3'b001);
        chk("p0_ld_wen", 32'({ld_state, write_enb_reg}), 32'b11);
        cyc(0, 0, 0, 2'd0, 3'b000, 0, 0, 3'b001);
        chk("p0_lp_wen", 32'({busy, write_enb_reg}), 32'b11);
        cyc(0, 0, 0, 2'd0, 3'b000, 0, 0, 3'b001);
        chk("p0_cpe", 32'(rst_int_reg), 32'd1);
        cyc(0, 0, 0, 2'd0, 3'b000, 0, 0, 3'b001);
        chk("p0_da", 32'(detect_addr), 32'd1);

        // FIFO-full stall then low_pkt_valid
        cyc(0, 1, 0, 2'd0, 3'b000, 0, 0, 3'b001);
        cyc(0, 1, 0, 2'd0, 3'b000, 0, 0, 3'b001);
        cyc(0, 1, 0, 2'd0, 3'b000, 1, 0, 3'b001);
        chk("ffs1", 32'({full_state, busy}), 32'b11);
        cyc(0, 1, 0, 2'd0, 3'b000, 1, 0, 3'b001);
        chk("ffs2", 32'({full_state, busy}), 32'b11);
        cyc(0, 0, 0, 2'd0, 3'b000, 0, 1, 3'b001);
        chk("laf", 32'({laf_state, busy, write_enb_reg}), 32'b111);
        cyc(0, 0, 0, 2'd0, 3'b000, 0, 1, 3'b001);
        cyc(0, 0, 0, 2'd0, 3'b000, 0, 0, 3'b001);
        cyc(0, 0, 0, 2'd0, 3'b000, 0, 0, 3'b001);
        chk("ffs_back_da", 32'(detect_addr), 32'd1);

        // Wait on busy port 2 until timeout
        cyc(0, 1, 0, 2'd2, 3'b000, 0, 0, 3'b000);
        for (int k = 0; k < WT - 1; k++) cyc(0, 1, 0, 2'd2, 3'b000, 0, 0, 3'b000);
        chk("wte_last", 32'({busy, drop_state}), 32'b10);
        cyc(0, 1, 0, 2'd2, 3'b000, 0, 0, 3'b000);
        chk("to_drop", 32'({drop_state, timeout_err, busy}), 32'b110);
        cyc(0, 1, 0, 2'd2, 3'b000, 0, 0, 3'b000);
        chk("to_pulse_end", 32'({drop_state, timeout_err}), 32'b10);
        cyc(0, 0, 0, 2'd2, 3'b000, 0, 0, 3'b000);
        chk("drop_exit", 32'(detect_addr), 32'd1);

        // Invalid address
        cyc(0, 1, 0, 2'd3, 3'b000, 0, 0, 3'b111);
        chk("bad_addr", 32'({drop_state, timeout_err, dest_sel}), 32'b10000);
        cyc(0, 1, 0, 2'd3, 3'b000, 0, 0, 3'b111);
        chk("bad_hold", 32'(drop_state), 32'd1);
        cyc(0, 0, 0, 2'd3, 3'b000, 0, 0, 3'b111);

        // FIFO drains on the very last wait cycle
        cyc(0, 1, 0, 2'd1, 3'b000, 0, 0, 3'b000);
        for (int k = 0; k < WT - 1; k++) cyc(0, 1, 0, 2'd1, 3'b000, 0, 0, 3'b000);
        cyc(0, 1, 0, 2'd1, 3'b000, 0, 0, 3'b010);
        chk("late_empty", 32'({lfd_state, timeout_err}), 32'b10);
        cyc(0, 1, 0, 2'd1, 3'b000, 0, 0, 3'b010);

        // Soft reset: other port ignored, own port aborts
        cyc(0, 1, 0, 2'd1, 3'b100, 0, 0, 3'b010);
        chk("sr_other", 32'({ld_state, dest_sel}), 32'b1010);
        cyc(0, 1, 0, 2'd1, 3'b010, 0, 0, 3'b010);
        chk("sr_own", 32'({detect_addr, dest_sel}), 32'b1000);

        // Reset while stalled on a full FIFO
        cyc(0, 1, 0, 2'd0, 3'b000, 0, 0, 3'b001);
        cyc(0, 1, 0, 2'd0, 3'b000, 0, 0, 3'b001);
        cyc(0, 1, 0, 2'd0, 3'b000, 1, 0, 3'b001);
        chk("pre_rst_ffs", 32'(full_state), 32'd1);
        cyc(1, 1, 0, 2'd0, 3'b000, 1, 0, 3'b001);
        chk("mid_rst", 32'({dut_flags, dest_sel}), 32'({10'b0100000000, 3'b000}));

        // Randomised traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 99) < 75),
                ($urandom_range(0, 99) < 20),
                AW'($urandom_range(0, 3)),
                ($urandom_range(0, 19) == 0) ? NP'($urandom_range(1, 7)) : NP'(0),
                ($urandom_range(0, 99) < 25),
                ($urandom_range(0, 99) < 20),
                {($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 30)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/router_fsm_nport.md
Name: router_fsm_nport

Overview:
Parametrised next-generation router control FSM, generalised from the fixed 3-port controller to NUM_PORTS destination channels. It sits between the input register/synchroniser and the per-port FIFOs, sequencing header decode, payload load, FIFO-full stalls and parity check. It adds three behaviours the 3-port controller lacks:
- a latched one-hot destination select;
- a bounded wait for a busy destination FIFO, with timeout;
- a DROP_PACKET state for invalid addresses and timed-out packets.

Parameters:
NUM_PORTS, 3, number of destination FIFOs/channels (2..16)
ADDR_W, 2, header address field width; must satisfy 2**ADDR_W >= NUM_PORTS
WAIT_TIMEOUT, 32, maximum cycles spent in WAIT_TILL_EMPTY before the packet is dropped (>=2)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
pkt_valid  in  1  source packet valid
parity_done  in  1  parity byte loaded (from register block)
data_in  in  ADDR_W  header address field
soft_reset  in  NUM_PORTS  per-port soft reset (FIFO read timeout)
fifo_full  in  1  full flag of currently selected FIFO
low_pkt_valid  in  1  pkt_valid fell while full (from register block)
fifo_empty  in  NUM_PORTS  per-port FIFO empty flags
busy  out  1  back-pressure to source
detect_addr  out  1  in DECODE_ADDRESS
lfd_state  out  1  in LOAD_FIRST_DATA
ld_state  out  1  in LOAD_DATA
laf_state  out  1  in LOAD_AFTER_FULL
full_state  out  1  in FIFO_FULL_STATE
write_enb_reg  out  1  register block may write FIFO
rst_int_reg  out  1  in CHECK_PARITY_ERROR
drop_state  out  1  in DROP_PACKET; payload discarded
timeout_err  out  1  one-cycle pulse on WTE timeout
dest_sel  out  NUM_PORTS  one-hot latched destination

Behaviour:
- Reset (sync, highest priority):
  - state = DECODE_ADDRESS, dest_sel = 0, wait counter = 0.
  - Outputs: detect_addr=1; all other outputs 0.
- Address latch: in DA with pkt_valid=1 and data_in < NUM_PORTS, dest_sel <= one-hot(data_in) on that edge; dest_sel holds until the next such latch. Out-of-range address clears dest_sel to 0.
- Transitions (evaluated each rising edge; "empty" = fifo_empty[data_in] in DA, fifo_empty & dest_sel elsewhere):
  - DA: pkt_valid & valid addr & empty -> LFD; pkt_valid & valid addr & !empty -> WTE; pkt_valid & addr >= NUM_PORTS -> DROP; else stay.
  - LFD -> LD unconditionally.
  - LD: fifo_full -> FFS; else !pkt_valid -> LP; else stay.
  - FFS: fifo_full -> stay; else -> LAF.
  - LAF: parity_done -> DA; else low_pkt_valid -> LP; else -> LD.
  - LP -> CPE unconditionally.
  - CPE: fifo_full -> FFS; else -> DA.
  - WTE: empty -> LFD. Otherwise, if counter == WAIT_TIMEOUT-1 -> DROP; else stay and increment the counter.
  - DROP: pkt_valid -> stay; else -> DA.
- Wait counter: width clog2(WAIT_TIMEOUT); cleared on every WTE entry. WTE lasts at most WAIT_TIMEOUT cycles.
- timeout_err: registered; high exactly the first cycle in DROP when entered from WTE by timeout. It stays 0 for an invalid-address drop.
- Soft reset: if (soft_reset & dest_sel) != 0 in any state except DA, next state = DA and dest_sel clears. This overrides all transitions except reset.
- Moore outputs:
  - busy = 1 in LFD, FFS, LAF, LP, CPE, WTE; 0 in DA, LD, DROP.
  - write_enb_reg = 1 in LD, LAF, LP.
  - State flags are one-hot decodes of state.
- Simultaneous events:
  - empty and timeout in the same WTE cycle -> LFD, no timeout_err.
  - fifo_full and !pkt_valid in LD -> FFS.
  - parity_done and low_pkt_valid in LAF -> DA.
- Reset mid-packet: return to DA next edge, regardless of pkt_valid.
- NUM_PORTS=3, ADDR_W=2, with an infinite wait (not reachable by parameter) would reproduce legacy behaviour; address 2'b11 now drops rather than hangs.

Test Plan:
- Reset, then pkt_valid=1, data_in=0, fifo_empty=3'b001 -> states DA,LFD,LD; drop pkt_valid -> LP,CPE,DA; dest_sel=3'b001; write_enb_reg high LD..LP.
- In LD, fifo_full=1 for 2 cycles, then 0 with low_pkt_valid=1 -> FFS,FFS,LAF,LP,CPE,DA; busy=1 throughout FFS/LAF.
- data_in=2, fifo_empty[2]=0, WAIT_TIMEOUT=4 -> WTE 4 cycles, DROP with timeout_err=1 for 1 cycle, busy=0; pkt_valid=0 -> DA.
- data_in=3 with NUM_PORTS=3 -> DROP next cycle, dest_sel=0, timeout_err=0; held while pkt_valid=1.
- NUM_PORTS=8, ADDR_W=3, data_in=5 in WTE, fifo_empty[5] rises on counter=WAIT_TIMEOUT-1 -> LFD, no timeout_err.
- In LD to port 1, soft_reset=3'b010 -> DA next edge, dest_sel=0; soft_reset=3'b100 (other port) -> no effect; reset asserted in FFS -> DA, all outputs at reset values.
